// File: rtl/systolic_seq_ctrl_pkg.sv
// systolic_seq_ctrl_pkg: shared constants, sequencer state enum and index-width helper
package systolic_seq_ctrl_pkg;
  localparam int N_DEFAULT = 8;
  localparam int K_W_DEFAULT = 8;
  typedef enum logic [2:0] {IDLE, LOAD_B, COMPUTE, DRAIN, DONE} seq_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// systolic_seq_ctrl_if: tile command, stall and array phase-enable bundle
interface systolic_seq_ctrl_if
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int K_W = K_W_DEFAULT
) ();
  localparam int IW = idx_w(N);
  logic start;
  logic [K_W-1:0] k_len;
  logic abort;
  logic mem_ready;
  logic busy;
  logic done;
  logic b_load_en;
  logic [IW-1:0] b_row_idx;
  logic acc_clr;
  logic [N-1:0] a_row_en;
  logic [K_W:0] a_k_idx;
  logic c_valid;
  logic [IW-1:0] c_row_idx;
  modport master (
    output start, k_len, abort, mem_ready,
    input busy, done, b_load_en, b_row_idx, acc_clr, a_row_en, a_k_idx, c_valid, c_row_idx
  );
  modport slave (
    input start, k_len, abort, mem_ready,
    output busy, done, b_load_en, b_row_idx, acc_clr, a_row_en, a_k_idx, c_valid, c_row_idx
  );
endinterface

// File: rtl/systolic_seq_ctrl_skew_gen.sv
// skew_gen: per-row skewed A valid, row i live for t in [i, i+k_len)
module skew_gen #(
  parameter int N = 8,
  parameter int K_W = 8
) (
  input  logic [K_W:0]   t,
  input  logic [K_W-1:0] k_len,
  input  logic           active,
  output logic [N-1:0]   row_en
);
  for (genvar i = 0; i < N; i++) begin : g_row
    assign row_en[i] = active && (t >= (K_W+1)'(i)) &&
                       ({1'b0, t} < (K_W+2)'(i) + {2'b00, k_len});
  end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: load-B / skewed-compute / drain-C sequencer for one tile GEMM
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int K_W = K_W_DEFAULT
) (
  input logic clk,
  input logic rst,
  systolic_seq_ctrl_if.slave bus
);
  localparam int IW = idx_w(N);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_LOAD_B = LOAD_B;
  localparam logic [2:0] S_COMPUTE = COMPUTE;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_DONE = DONE;
  logic [2:0] state, state_n;
  logic [K_W:0] cnt, cnt_n, last;
  logic [K_W-1:0] k_q;
  logic act, cnt_end, take;
  assign act = bus.mem_ready;
  assign take = state == S_IDLE && bus.start && !bus.abort;
  // last phase-counter value: N-1 for load/drain, k_len+2N-3 for compute
  always_comb last = state == S_COMPUTE ? {1'b0, k_q} + (K_W+1)'(2*N-3) : (K_W+1)'(N-1);
  assign cnt_end = cnt == last;
  // next state and shared phase counter; abort wins, stalls freeze everything
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (bus.abort) begin
      state_n = S_IDLE;
      cnt_n = '0;
    end else if (state == S_IDLE) begin
      if (bus.start) state_n = bus.k_len == '0 ? S_DONE : S_LOAD_B;
    end else if (state == S_DONE) begin
      state_n = S_IDLE;
    end else if (act) begin
      cnt_n = cnt_end ? '0 : cnt + 1'b1;
      if (cnt_end) state_n = state == S_LOAD_B ? S_COMPUTE : state == S_COMPUTE ? S_DRAIN : S_DONE;
    end
  end
  // state, counter and captured K registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      k_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (take) k_q <= bus.k_len;
    end
  end
  assign bus.busy = state == S_LOAD_B || state == S_COMPUTE || state == S_DRAIN;
  assign bus.done = state == S_DONE;
  assign bus.b_load_en = state == S_LOAD_B && act;
  assign bus.b_row_idx = state == S_LOAD_B ? cnt[IW-1:0] : '0;
  assign bus.acc_clr = state == S_COMPUTE && act && cnt == '0;
  assign bus.a_k_idx = state == S_COMPUTE ? cnt : '0;
  assign bus.c_valid = state == S_DRAIN && act;
  assign bus.c_row_idx = state == S_DRAIN ? cnt[IW-1:0] : '0;
  skew_gen #(.N(N), .K_W(K_W)) u_skew (
    .t(cnt),
    .k_len(k_q),
    .active(state == S_COMPUTE && act),
    .row_en(bus.a_row_en)
  );
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: directed and randomized tile runs against an active-cycle progress model
module tb_systolic_seq_ctrl;
  localparam int N = 8;
  localparam int KW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int dut_dones = 0;
  int exp_dones = 0;
  systolic_seq_ctrl_if #(.N(N), .K_W(KW)) bus ();
  systolic_seq_ctrl #(.N(N), .K_W(KW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  // count real done pulses seen on the bus
  always @(negedge clk) if (bus.done === 1'b1) dut_dones++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // expected outputs from the number s of active cycles consumed so far in a tile of K=k
  task automatic check_outs(input int k, input int s, input bit in_tile, input logic mr);
    int tt = k + 2*N - 2;
    int tot = (k == 0) ? 0 : 2*N + tt;
    int t = s - N;
    bit dn, ld, cp, dr;
    logic [N-1:0] en;
    dn = in_tile && s == tot;
    ld = in_tile && !dn && s < N;
    cp = in_tile && !dn && s >= N && s < N + tt;
    dr = in_tile && !dn && s >= N + tt;
    for (int i = 0; i < N; i++) en[i] = cp && mr && t >= i && t < i + k;
    chk("busy", 32'(bus.busy), 32'(in_tile && !dn));
    chk("done", 32'(bus.done), 32'(dn));
    chk("b_load_en", 32'(bus.b_load_en), 32'(ld && mr));
    chk("b_row_idx", 32'(bus.b_row_idx), ld ? s : 0);
    chk("acc_clr", 32'(bus.acc_clr), 32'(cp && mr && t == 0));
    chk("a_row_en", 32'(bus.a_row_en), 32'(en));
    chk("a_k_idx", 32'(bus.a_k_idx), cp ? t : 0);
    chk("c_valid", 32'(bus.c_valid), 32'(dr && mr));
    chk("c_row_idx", 32'(bus.c_row_idx), dr ? s - N - tt : 0);
  endtask
  // mode 0 no stall, 1 random stalls, 2 three-cycle stall at t=5; ev 1 abort+start, 2 async reset
  task automatic run_tile(input int k, input int mode, input int ev_at, input int ev_kind);
    int s = 0;
    int c = 1;
    int stall_left = 0;
    int stalls = 0;
    int tot = (k == 0) ? 0 : 4*N - 2 + k;
    bit fin = 0;
    bus.start = 1'b1;
    bus.k_len = k[KW-1:0];
    bus.abort = 1'b0;
    bus.mem_ready = 1'($urandom_range(0, 1));
    #2 check_outs(k, 0, 0, bus.mem_ready);
    @(posedge clk);
    #1;
    while (!fin) begin
      logic mr;
      bit ev;
      ev = ev_kind != 0 && s == ev_at;
      mr = 1'b1;
      if (mode == 1) mr = $urandom_range(0, 3) != 0;
      if (mode == 2 && s == N + 5 && stalls == 0) stall_left = 3;
      if (stall_left > 0) begin
        mr = 1'b0;
        stall_left--;
      end
      if (ev) mr = 1'b1;
      if (!mr && s < tot) stalls++;
      bus.mem_ready = mr;
      bus.start = (ev && ev_kind == 1) ? 1'b1 : $urandom_range(0, 5) == 0;
      bus.k_len = KW'($urandom);
      bus.abort = ev && ev_kind == 1;
      #2 check_outs(k, s, 1, mr);
      if (ev && ev_kind == 2) begin
        rst = 1'b1;
        bus.start = 1'b0;
        #1 check_outs(k, 0, 0, mr);
        @(posedge clk);
        #1 check_outs(k, 0, 0, mr);
        rst = 1'b0;
        fin = 1;
      end else begin
        if (s == tot) begin
          chk("done_cycle", c, 1 + tot + stalls);
          exp_dones++;
          fin = 1;
        end
        @(posedge clk);
        #1;
        c++;
        if (ev) begin
          bus.start = 1'b0;
          bus.abort = 1'b0;
          #2 check_outs(k, 0, 0, bus.mem_ready);
          fin = 1;
        end else if (mr) s++;
      end
      if (c > 3000) begin
        chk("timeout", c, 0);
        fin = 1;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #2 check_outs(k, 0, 0, bus.mem_ready);
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.abort = 1'b0;
    bus.mem_ready = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outs(0, 0, 0, 1'b1);
    bus.start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 check_outs(0, 0, 0, 1'b1);
    run_tile(8, 0, -1, 0);
    run_tile(1, 0, -1, 0);
    run_tile(0, 0, -1, 0);
    run_tile(8, 2, -1, 0);
    run_tile(8, 0, N + 10, 1);
    run_tile(8, 0, -1, 0);
    run_tile(8, 0, 2*N + 22 - N + 3 + N - N + N - N, 2);
    run_tile(5, 0, -1, 0);
    for (int r = 0; r < 8; r++) run_tile($urandom_range(0, 20), 1, -1, 0);
    run_tile(255, 0, -1, 0);
    run_tile(3, 1, N + 2, 1);
    run_tile(2, 1, -1, 0);
    chk("done_count", dut_dones, exp_dones);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
